// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add over a 2*WIDTH accumulator. DIV/DIVU use restoring
// division that produces one quotient bit per cycle. Each operation takes
// WIDTH RUN cycles. The sign fix-up is folded into the last iteration, so HI/LO
// and o_done update on the same edge that returns the FSM to IDLE.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 is_div_q;   // 1 = divide, 0 = multiply
    logic                 neg_q;      // negate product / quotient at the end
    logic                 neg_rem_q;  // remainder follows the dividend sign
    logic                 div0_q;     // divisor was zero
    logic [WIDTH-1:0]     b_q;        // multiplicand / divisor magnitude
    logic [2*WIDTH-1:0]   acc_q;      // product accumulator; low half holds dividend/quotient
    logic [WIDTH:0]       rem_q;      // partial remainder
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;

    // Operand magnitudes and sign flags formed at start time
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // One iteration of the datapath, plus the fixed-up final result
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc_d;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_d;
    logic [WIDTH-1:0]     quo_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;

    // Magnitudes of the incoming operands; only MULT/DIV (i_op[0]=1) are signed
    always_comb begin
        a_neg = i_op[0] & i_rs[WIDTH-1];
        b_neg = i_op[0] & i_rt[WIDTH-1];
        a_mag = a_neg ? (~i_rs + 1'b1) : i_rs;
        b_mag = b_neg ? (~i_rt + 1'b1) : i_rt;
    end

    // Next iteration step for both algorithms and the sign-corrected result
    always_comb begin
        // shift-add: add multiplicand into the upper half when LSB set, then shift right
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

        // restoring divide: bring in next dividend bit, subtract if it fits
        rem_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        if (rem_shift >= {1'b0, b_q}) begin
            rem_d = rem_shift - {1'b0, b_q};
            quo_d = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_shift;
            quo_d = {acc_q[WIDTH-2:0], 1'b0};
        end

        acc_d = is_div_q ? {acc_q[2*WIDTH-1:WIDTH], quo_d} : mul_acc_d;

        prod_fix = neg_q ? (~mul_acc_d + 1'b1) : mul_acc_d;
        // divide by zero naturally leaves rem = |dividend|; the remainder sign
        // fix then restores the original dividend, so only LO needs forcing
        quo_fix  = div0_q ? '1 : (neg_q ? (~quo_d + 1'b1) : quo_d);
        rem_fix  = neg_rem_q ? (~rem_d[WIDTH-1:0] + 1'b1) : rem_d[WIDTH-1:0];

        hi_d = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        is_div_q  <= i_op[1];
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= i_op[1] && (i_rt == '0);
                        b_q       <= b_mag;
                        acc_q     <= {{WIDTH{1'b0}}, a_mag};
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        if (i_mthi) hi_q <= i_rs;
                        if (i_mtlo) lo_q <= i_rs;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
